// File: rtl/riscv_defines.sv
// Shared definitions for the string-op execution unit: operator encodings,
// sequencer states and the ASCII constants used by the byte transforms.
package riscv_defines;

  localparam int STR_OP_WIDTH = 2;

  localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 2'd0;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 2'd1;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 2'd2;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } str_seq_state_e;

  localparam logic [7:0] ASCII_a    = 8'h61;
  localparam logic [7:0] ASCII_z    = 8'h7A;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_Z    = 8'h5A;
  localparam logic [7:0] ASCII_NUL  = 8'h00;
  localparam logic [7:0] CASE_DELTA = 8'h20;

  localparam logic [7:0] ROT13_SHIFT = 8'd13;

endpackage

// File: rtl/riscv_str_byte_xform.sv
// Combinational single-byte transform for the string-op unit.
// Non-letters (including bytes >= 0x80) always pass through unchanged.
module riscv_str_byte_xform
  import riscv_defines::*;
(
  input  logic [STR_OP_WIDTH-1:0] op,
  input  logic [7:0]              din,
  output logic [7:0]              dout
);

  logic       is_lower;
  logic       is_upper;
  logic [7:0] folded;

  assign is_lower = (din >= ASCII_a) && (din <= ASCII_z);
  assign is_upper = (din >= ASCII_A) && (din <= ASCII_Z);
  // Lowercase view of a letter, so LEET matches both cases with one table.
  assign folded   = din | CASE_DELTA;

  always_comb begin
    dout = din;
    unique case (op)
      STR_OP_UPPER: begin
        if (is_lower) dout = din - CASE_DELTA;
      end
      STR_OP_LOWER: begin
        if (is_upper) dout = din + CASE_DELTA;
      end
      STR_OP_LEET: begin
        if (is_lower || is_upper) begin
          case (folded)
            8'h61:   dout = 8'h34;  // a -> 4
            8'h65:   dout = 8'h33;  // e -> 3
            8'h69:   dout = 8'h31;  // i -> 1
            8'h6F:   dout = 8'h30;  // o -> 0
            8'h73:   dout = 8'h35;  // s -> 5
            8'h74:   dout = 8'h37;  // t -> 7
            default: dout = din;
          endcase
        end
      end
      STR_OP_ROT13: begin
        // First half of each alphabet moves up, second half wraps down.
        if (is_lower) begin
          dout = (din < ASCII_a + ROT13_SHIFT) ? din + ROT13_SHIFT : din - ROT13_SHIFT;
        end else if (is_upper) begin
          dout = (din < ASCII_A + ROT13_SHIFT) ? din + ROT13_SHIFT : din - ROT13_SHIFT;
        end
      end
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/riscv_str_ops_seq.sv
// Byte-serial string-op execution unit: accepts one packed-ASCII word,
// transforms BYTES_PER_CYCLE bytes per BUSY cycle and hands the result to writeback.
module riscv_str_ops_seq
  import riscv_defines::*;
#(
  parameter int BYTES_PER_CYCLE = 1,
  parameter bit STOP_AT_NUL     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic [STR_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             operand_i,
  output logic                    ready_o,
  input  logic                    flush_i,
  output logic [31:0]             result_o,
  output logic                    result_valid_o,
  input  logic                    wb_ready_i,
  output logic                    busy_o
);

  localparam logic [1:0] STEP     = 2'(BYTES_PER_CYCLE % 4);
  localparam logic [1:0] LAST_OFF = 2'(BYTES_PER_CYCLE - 1);

  str_seq_state_e          state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic [STR_OP_WIDTH-1:0] op_q, op_d;
  logic [31:0]             operand_q, operand_d;
  logic [31:0]             result_q, result_d;

  logic [31:0] work_result;
  logic [1:0]  last_idx;
  logic [1:0]  lane_pos;
  logic        nul_hit;
  logic        accept;

  logic [7:0] lane_in  [BYTES_PER_CYCLE];
  logic [7:0] lane_out [BYTES_PER_CYCLE];

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    logic [1:0] pos;
    assign pos        = idx_q + 2'(j);
    assign lane_in[j] = operand_q[{pos, 3'b000} +: 8];

    riscv_str_byte_xform u_xform (
      .op   (op_q),
      .din  (lane_in[j]),
      .dout (lane_out[j])
    );
  end

  // Merge this cycle's lanes into the result. Once a NUL is seen, it and every
  // byte above it (in this and later lanes) keep their original value.
  always_comb begin
    work_result = result_q;
    nul_hit     = 1'b0;
    lane_pos    = '0;
    last_idx    = idx_q + LAST_OFF;
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      lane_pos = idx_q + 2'(j);
      if (nul_hit) begin
        work_result[{lane_pos, 3'b000} +: 8] = lane_in[j];
      end else begin
        work_result[{lane_pos, 3'b000} +: 8] = lane_out[j];
        if (STOP_AT_NUL && (lane_in[j] == ASCII_NUL)) nul_hit = 1'b1;
      end
    end
    if (nul_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (2'(b) > last_idx) work_result[8*b +: 8] = operand_q[8*b +: 8];
      end
    end
  end

  assign ready_o        = (state_q == IDLE) || ((state_q == DONE) && wb_ready_i);
  assign busy_o         = (state_q == BUSY);
  assign result_valid_o = (state_q == DONE);
  assign result_o       = result_q;
  assign accept         = enable_i && ready_o && !flush_i;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    operand_d = operand_q;
    result_d  = result_q;
    if (flush_i) begin
      state_d  = IDLE;
      idx_d    = '0;
      result_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_d   = BUSY;
            idx_d     = '0;
            op_d      = operator_i;
            operand_d = operand_i;
            result_d  = '0;
          end else if ((state_q == DONE) && wb_ready_i) begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          result_d = work_result;
          idx_d    = idx_q + STEP;
          if ((last_idx == 2'd3) || nul_hit) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      op_q      <= '0;
      operand_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_riscv_str_ops_seq.sv
// Directed bench for riscv_str_ops_seq: three instances (1 byte/cycle with and
// without NUL stop, 4 bytes/cycle) share stimulus; expectations are hand-computed.
module tb_riscv_str_ops_seq;
  import riscv_defines::*;

  logic                    clk;
  logic                    rst_n;
  logic                    enable;
  logic [STR_OP_WIDTH-1:0] operator;
  logic [31:0]             operand;
  logic                    flush;
  logic                    wb_ready;

  logic        rdy0, val0, bsy0, rdy1, val1, bsy1, rdy2, val2, bsy2;
  logic [31:0] res0, res1, res2;

  int checks = 0;
  int errors = 0;
  int lat0, lat1, lat2;

  riscv_str_ops_seq #(.BYTES_PER_CYCLE(1), .STOP_AT_NUL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(operator), .operand_i(operand),
    .ready_o(rdy0), .flush_i(flush), .result_o(res0), .result_valid_o(val0),
    .wb_ready_i(wb_ready), .busy_o(bsy0));

  riscv_str_ops_seq #(.BYTES_PER_CYCLE(1), .STOP_AT_NUL(1'b0)) dut_nn (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(operator), .operand_i(operand),
    .ready_o(rdy1), .flush_i(flush), .result_o(res1), .result_valid_o(val1),
    .wb_ready_i(wb_ready), .busy_o(bsy1));

  riscv_str_ops_seq #(.BYTES_PER_CYCLE(4), .STOP_AT_NUL(1'b1)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(operator), .operand_i(operand),
    .ready_o(rdy2), .flush_i(flush), .result_o(res2), .result_valid_o(val2),
    .wb_ready_i(wb_ready), .busy_o(bsy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Present one request for exactly one rising edge; returns at the negedge after it.
  task automatic issue(input logic [STR_OP_WIDTH-1:0] op, input logic [31:0] opd);
    @(negedge clk);
    operator = op;
    operand  = opd;
    enable   = 1'b1;
    @(negedge clk);
    enable   = 1'b0;
  endtask

  // Record, per instance, how many edges after acceptance result_valid rose (99 = never).
  task automatic wait_all();
    lat0 = 99; lat1 = 99; lat2 = 99;
    for (int c = 0; c < 10; c++) begin
      if (val0 && lat0 == 99) lat0 = c;
      if (val1 && lat1 == 99) lat1 = c;
      if (val2 && lat2 == 99) lat2 = c;
      if (lat0 != 99 && lat1 != 99 && lat2 != 99) break;
      @(negedge clk);
    end
  endtask

  task automatic retire();
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rdy0); end
    checks++; if (bsy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bsy0); end
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", val0); end
    checks++; if (res0 !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", res0); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_upper_plain();
    issue(STR_OP_UPPER, 32'h64636261);
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL plain_ready_drop got %b exp 0", rdy0); end
    checks++; if (bsy0 !== 1'b1) begin errors++; $display("FAIL plain_busy got %b exp 1", bsy0); end
    operand = 32'hFFFF_FFFF;
    enable  = 1'b1;
    wait_all();
    enable  = 1'b0;
    checks++; if (lat0 !== 4) begin errors++; $display("FAIL plain_latency got %0d exp 4", lat0); end
    checks++; if (res0 !== 32'h44434241) begin errors++; $display("FAIL plain_result got %h exp 44434241", res0); end
    checks++; if (lat2 !== 1) begin errors++; $display("FAIL w4_latency got %0d exp 1", lat2); end
    checks++; if (res2 !== 32'h44434241) begin errors++; $display("FAIL w4_result got %h exp 44434241", res2); end
    retire();
    checks++; if (rdy0 !== 1'b1 || val0 !== 1'b0) begin
      errors++; $display("FAIL plain_retire ready %b valid %b exp ready 1 valid 0", rdy0, val0);
    end
  endtask

  task automatic test_ops();
    logic [STR_OP_WIDTH-1:0] op_tab [5];
    logic [31:0] in_tab [5];
    logic [31:0] exp_tab [5];
    op_tab[0] = STR_OP_ROT13; in_tab[0] = 32'h7A6E4D41; exp_tab[0] = 32'h6D615A4E;
    op_tab[1] = STR_OP_LEET;  in_tab[1] = 32'h74736F65; exp_tab[1] = 32'h37353033;
    op_tab[2] = STR_OP_LOWER; in_tab[2] = 32'h5A412180; exp_tab[2] = 32'h7A612180;
    op_tab[3] = STR_OP_UPPER; in_tab[3] = 32'h607B7A61; exp_tab[3] = 32'h607B5A41;
    op_tab[4] = STR_OP_ROT13; in_tab[4] = 32'h5A6D4E7A; exp_tab[4] = 32'h4D7A416D;
    for (int i = 0; i < 5; i++) begin
      issue(op_tab[i], in_tab[i]);
      wait_all();
      checks++; if (res0 !== exp_tab[i] || lat0 !== 4) begin
        errors++; $display("FAIL op%0d_b1 got %h lat %0d exp %h lat 4", i, res0, lat0, exp_tab[i]);
      end
      checks++; if (res2 !== exp_tab[i]) begin
        errors++; $display("FAIL op%0d_b4 got %h exp %h", i, res2, exp_tab[i]);
      end
      retire();
    end
  endtask

  task automatic test_early_nul();
    issue(STR_OP_UPPER, 32'h61006261);
    wait_all();
    checks++; if (res0 !== 32'h61004241 || lat0 !== 3) begin
      errors++; $display("FAIL nul2_stop got %h lat %0d exp 61004241 lat 3", res0, lat0);
    end
    checks++; if (res1 !== 32'h41004241 || lat1 !== 4) begin
      errors++; $display("FAIL nul2_nostop got %h lat %0d exp 41004241 lat 4", res1, lat1);
    end
    checks++; if (res2 !== 32'h61004241 || lat2 !== 1) begin
      errors++; $display("FAIL nul2_w4 got %h lat %0d exp 61004241 lat 1", res2, lat2);
    end
    retire();
    issue(STR_OP_UPPER, 32'h63626100);
    wait_all();
    checks++; if (res0 !== 32'h63626100 || lat0 !== 1) begin
      errors++; $display("FAIL nul0_stop got %h lat %0d exp 63626100 lat 1", res0, lat0);
    end
    checks++; if (res1 !== 32'h43424100 || lat1 !== 4) begin
      errors++; $display("FAIL nul0_nostop got %h lat %0d exp 43424100 lat 4", res1, lat1);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    issue(STR_OP_UPPER, 32'h64636261);
    wait_all();
    for (int i = 0; i < 5; i++) begin
      operator = STR_OP_LOWER;
      operand  = 32'h5A5A5A5A;
      enable   = 1'b1;
      @(negedge clk);
      checks++; if (res0 !== 32'h44434241 || val0 !== 1'b1 || bsy0 !== 1'b0 || rdy0 !== 1'b0) begin
        errors++; $display("FAIL hold%0d result %h valid %b busy %b ready %b exp 44434241 1 0 0",
                           i, res0, val0, bsy0, rdy0);
      end
    end
    operand  = 32'h44434241;
    wb_ready = 1'b1;
    #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", rdy0); end
    @(negedge clk);
    enable   = 1'b0;
    wb_ready = 1'b0;
    checks++; if (bsy0 !== 1'b1 || val0 !== 1'b0) begin
      errors++; $display("FAIL b2b_no_bubble busy %b valid %b exp busy 1 valid 0", bsy0, val0);
    end
    wait_all();
    checks++; if (res0 !== 32'h64636261 || lat0 !== 4) begin
      errors++; $display("FAIL b2b_result got %h lat %0d exp 64636261 lat 4", res0, lat0);
    end
    retire();
  endtask

  task automatic test_flush();
    int seen;
    issue(STR_OP_UPPER, 32'h64636261);
    @(negedge clk);
    flush   = 1'b1;
    enable  = 1'b1;
    operand = 32'h61616161;
    @(negedge clk);
    flush   = 1'b0;
    enable  = 1'b0;
    checks++; if (rdy0 !== 1'b1 || bsy0 !== 1'b0 || val0 !== 1'b0 || res0 !== 32'h0) begin
      errors++; $display("FAIL flush_state ready %b busy %b valid %b result %h exp 1 0 0 0",
                         rdy0, bsy0, val0, res0);
    end
    checks++; if (val2 !== 1'b0 || res2 !== 32'h0) begin
      errors++; $display("FAIL flush_w4 valid %b result %h exp 0 0", val2, res2);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (val0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_valid got %0d pulses exp 0", seen); end
    flush  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    flush  = 1'b0;
    enable = 1'b0;
    checks++; if (bsy0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++; $display("FAIL flush_blocks_accept busy %b ready %b exp 0 1", bsy0, rdy0);
    end
  endtask

  task automatic test_midop_reset();
    issue(STR_OP_UPPER, 32'h64636261);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rdy0 !== 1'b1 || bsy0 !== 1'b0 || val0 !== 1'b0 || res0 !== 32'h0) begin
      errors++; $display("FAIL midop_reset ready %b busy %b valid %b result %h exp 1 0 0 0",
                         rdy0, bsy0, val0, res0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bsy0 !== 1'b0 || res0 !== 32'h0) begin
      errors++; $display("FAIL post_reset busy %b result %h exp 0 0", bsy0, res0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    operator = STR_OP_UPPER;
    operand  = 32'h0;
    flush    = 1'b0;
    wb_ready = 1'b0;
    test_reset();
    test_upper_plain();
    test_ops();
    test_early_nul();
    test_back_to_back();
    test_flush();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
